// File: rtl/std_countones_seq.sv
// std_countones_seq: sequential popcount, one CW-bit chunk per cycle.
// Ports: i_valid/o_ready/i_data in, o_valid/i_ready/o_ones out, o_busy.
module std_countones_seq #(
  parameter int W  = 64,
  parameter int CW = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [W-1:0]                      i_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [(W > 1 ? $clog2(W)+1 : 1)-1:0] o_ones,
  output logic                              o_busy
);

  localparam int NCHUNK = (W + CW - 1) / CW;
  localparam int CLOGW  = (W > 1) ? $clog2(W) + 1 : 1;
  localparam int PCW    = (CW > 1) ? $clog2(CW) + 1 : 1;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SW     = NCHUNK * CW;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    shadow_q, shadow_d;
  logic [CLOGW-1:0] acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [CW-1:0]    chunk;
  logic [PCW-1:0]   chunk_ones;
  logic             last;

  // Single shared counting slice, steered by the chunk index.
  assign chunk = CW'(shadow_q >> (int'(idx_q) * CW));
  assign last  = (idx_q == IW'(NCHUNK - 1));

  always_comb begin
    chunk_ones = '0;
    for (int i = 0; i < CW; i++) begin
      chunk_ones = chunk_ones + PCW'(chunk[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          // Zero-extension keeps the padding of the last chunk at 0.
          shadow_d = SW'(i_data);
          acc_d    = '0;
          idx_d    = '0;
          state_d  = COUNT;
        end
      end
      COUNT: begin
        acc_d = acc_q + CLOGW'(chunk_ones);
        if (last) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
    end
  end

  // Outputs decode from state only; no path from i_valid/i_ready.
  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q != IDLE);
  assign o_ones  = o_valid ? acc_q : '0;

endmodule

// File: tb/tb_std_countones_seq.sv
// tb_std_countones_seq: scoreboard bench for std_countones_seq.
// Four instances cover 64/16, 20/8, 1/1 and 16/16 configurations.
module tb_std_countones_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] v  = '0;
  logic [3:0] ri = '0;
  logic [3:0] vo, ro, busy;

  logic [63:0] d0 = '0;
  logic [19:0] d1 = '0;
  logic [0:0]  d2 = '0;
  logic [15:0] d3 = '0;

  logic [6:0] ones0;
  logic [5:0] ones1;
  logic [0:0] ones2;
  logic [4:0] ones3;

  int tests_run = 0;
  int failures  = 0;
  int sb[$];

  std_countones_seq #(.W(64), .CW(16)) u0 (
    .i_clk(clk), .i_rst(rst), .i_valid(v[0]), .o_ready(ro[0]),
    .i_data(d0), .o_valid(vo[0]), .i_ready(ri[0]), .o_ones(ones0),
    .o_busy(busy[0])
  );
  std_countones_seq #(.W(20), .CW(8)) u1 (
    .i_clk(clk), .i_rst(rst), .i_valid(v[1]), .o_ready(ro[1]),
    .i_data(d1), .o_valid(vo[1]), .i_ready(ri[1]), .o_ones(ones1),
    .o_busy(busy[1])
  );
  std_countones_seq #(.W(1), .CW(1)) u2 (
    .i_clk(clk), .i_rst(rst), .i_valid(v[2]), .o_ready(ro[2]),
    .i_data(d2), .o_valid(vo[2]), .i_ready(ri[2]), .o_ones(ones2),
    .o_busy(busy[2])
  );
  std_countones_seq #(.W(16), .CW(16)) u3 (
    .i_clk(clk), .i_rst(rst), .i_valid(v[3]), .o_ready(ro[3]),
    .i_data(d3), .o_valid(vo[3]), .i_ready(ri[3]), .o_ones(ones3),
    .o_busy(busy[3])
  );

  function automatic int popcnt(input logic [63:0] d, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(d[i]);
    return c;
  endfunction

  function automatic int get_ones(input int w);
    case (w)
      0: return int'(ones0);
      1: return int'(ones1);
      2: return int'(ones2);
      default: return int'(ones3);
    endcase
  endfunction

  task automatic set_data(input int w, input logic [63:0] d);
    case (w)
      0: d0 = d;
      1: d1 = d[19:0];
      2: d2 = d[0:0];
      default: d3 = d[15:0];
    endcase
  endtask

  function automatic int pop_exp();
    if (sb.size() == 0) return -1;
    return sb.pop_front();
  endfunction

  // Drives one word; returns #1 after the accepting edge (cycle 0 end).
  task automatic accept(input int w, input logic [63:0] d, input int n);
    @(negedge clk);
    v[w] = 1'b1;
    set_data(w, d);
    for (int k = 0; k < 20 && !ro[w]; k++) @(negedge clk);
    sb.push_back(popcnt(d, n));
    @(posedge clk);
    #1;
    v[w] = 1'b0;
    set_data(w, {$urandom, $urandom});
  endtask

  // Counts negedges until o_valid; lat = -1 when the bound expires.
  task automatic wait_valid(input int w, input int start, output int lat);
    lat = -1;
    for (int k = start + 1; k < start + 30; k++) begin
      @(negedge clk);
      if (vo[w]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_out(input int w);
    ri[w] = 1'b1;
    @(posedge clk);
    #1;
    ri[w] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (ro[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b want 1", ro[0]);
    end
    tests_run++;
    if (vo[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got %b want 0", vo[0]);
    end
    tests_run++;
    if (busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got %b want 0", busy[0]);
    end
    tests_run++;
    if (ones0 !== 7'd0) begin
      failures++;
      $display("FAIL reset_ones got %0d want 0", ones0);
    end
    rst = 1'b0;
  endtask

  task automatic test_all_ones();
    int lat, exp;
    sb.delete();
    accept(0, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    @(negedge clk);
    tests_run++;
    if (busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL count_busy got %b want 1", busy[0]);
    end
    tests_run++;
    if (ro[0] !== 1'b0) begin
      failures++;
      $display("FAIL count_ready got %b want 0", ro[0]);
    end
    tests_run++;
    if (ones0 !== 7'd0) begin
      failures++;
      $display("FAIL count_ones got %0d want 0", ones0);
    end
    wait_valid(0, 1, lat);
    tests_run++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL allones_lat got %0d want 5", lat);
    end
    exp = pop_exp();
    tests_run++;
    if (get_ones(0) !== exp) begin
      failures++;
      $display("FAIL allones_val got %0d want %0d", get_ones(0), exp);
    end
    release_out(0);
    accept(0, 64'h0, 64);
    wait_valid(0, 0, lat);
    exp = pop_exp();
    tests_run++;
    if (lat !== 5 || get_ones(0) !== exp) begin
      failures++;
      $display("FAIL zero_val got %0d lat %0d want %0d lat 5",
               get_ones(0), lat, exp);
    end
    release_out(0);
  endtask

  task automatic test_partial_chunk();
    int lat, exp;
    sb.delete();
    accept(1, 64'hFFFFF, 20);
    wait_valid(1, 0, lat);
    tests_run++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL partial_lat got %0d want 4", lat);
    end
    exp = pop_exp();
    tests_run++;
    if (get_ones(1) !== exp) begin
      failures++;
      $display("FAIL partial_ff got %0d want %0d", get_ones(1), exp);
    end
    release_out(1);
    accept(1, 64'h80001, 20);
    wait_valid(1, 0, lat);
    exp = pop_exp();
    tests_run++;
    if (get_ones(1) !== exp) begin
      failures++;
      $display("FAIL partial_81 got %0d want %0d", get_ones(1), exp);
    end
    release_out(1);
  endtask

  task automatic test_backpressure();
    int lat, exp;
    sb.delete();
    accept(0, 64'h0000_0001_FFFF_FFFF, 64);
    wait_valid(0, 0, lat);
    exp = pop_exp();
    tests_run++;
    if (get_ones(0) !== exp) begin
      failures++;
      $display("FAIL bp_val got %0d want %0d", get_ones(0), exp);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (vo[0] !== 1'b1 || get_ones(0) !== exp || ro[0] !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d got v%b o%0d r%b want v1 o%0d r0",
                 c, vo[0], get_ones(0), ro[0], exp);
      end
    end
    release_out(0);
    tests_run++;
    if (ro[0] !== 1'b1 || vo[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got r%b v%b want r1 v0", ro[0], vo[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w;
    int sent = 0, got = 0, last_t = -1, exp;
    sb.delete();
    @(negedge clk);
    ri[0] = 1'b1;
    v[0]  = 1'b1;
    for (int t = 0; t < 60 && got < 3; t++) begin
      if (vo[0]) begin
        exp = pop_exp();
        tests_run++;
        if (get_ones(0) !== exp) begin
          failures++;
          $display("FAIL b2b_val%0d got %0d want %0d", got, get_ones(0), exp);
        end
        if (got > 0) begin
          tests_run++;
          if (t - last_t !== 6) begin
            failures++;
            $display("FAIL b2b_period got %0d want 6", t - last_t);
          end
        end
        last_t = t;
        got++;
      end
      if (ro[0] && sent < 3) begin
        case (sent)
          0: w = 64'h0F0F_0F0F_0F0F_0F0F;
          1: w = 64'h1;
          default: w = 64'h8000_0000_0000_0001;
        endcase
        d0 = w;
        sb.push_back(popcnt(w, 64));
        sent++;
      end else if (ro[0]) begin
        v[0] = 1'b0;
      end else begin
        d0 = {$urandom, $urandom};
      end
      if (got < 3) @(negedge clk);
    end
    tests_run++;
    if (got !== 3) begin
      failures++;
      $display("FAIL b2b_count got %0d want 3", got);
    end
    @(posedge clk);
    #1;
    v[0]  = 1'b0;
    ri[0] = 1'b0;
  endtask

  task automatic test_stability_reset();
    int lat, exp;
    sb.delete();
    accept(0, 64'hDEAD_BEEF_0000_1234, 64);
    wait_valid(0, 0, lat);
    exp = pop_exp();
    tests_run++;
    if (get_ones(0) !== exp) begin
      failures++;
      $display("FAIL stable_val got %0d want %0d", get_ones(0), exp);
    end
    release_out(0);
    accept(0, 64'hFFFF_0000_FFFF_0000, 64);
    @(negedge clk);
    tests_run++;
    if (busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst_busy got %b want 1", busy[0]);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (vo[0] !== 1'b0 || busy[0] !== 1'b0 ||
        ones0 !== 7'd0 || ro[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_rst got v%b b%b o%0d r%b want v0 b0 o0 r1",
               vo[0], busy[0], ones0, ro[0]);
    end
    sb.delete();
    #1;
    rst = 1'b0;
    accept(0, 64'h0123_4567_89AB_CDEF, 64);
    wait_valid(0, 0, lat);
    exp = pop_exp();
    tests_run++;
    if (lat !== 5 || get_ones(0) !== exp) begin
      failures++;
      $display("FAIL post_rst got %0d lat %0d want %0d lat 5",
               get_ones(0), lat, exp);
    end
    release_out(0);
  endtask

  task automatic test_degenerate();
    int lat, exp;
    sb.delete();
    accept(2, 64'h1, 1);
    wait_valid(2, 0, lat);
    exp = pop_exp();
    tests_run++;
    if (lat !== 2 || get_ones(2) !== exp) begin
      failures++;
      $display("FAIL w1 got %0d lat %0d want %0d lat 2",
               get_ones(2), lat, exp);
    end
    release_out(2);
    accept(3, 64'hA5A5, 16);
    wait_valid(3, 0, lat);
    exp = pop_exp();
    tests_run++;
    if (lat !== 2 || get_ones(3) !== exp) begin
      failures++;
      $display("FAIL w16 got %0d lat %0d want %0d lat 2",
               get_ones(3), lat, exp);
    end
    release_out(3);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_partial_chunk();
    test_backpressure();
    test_back_to_back();
    test_stability_reset();
    test_degenerate();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
